// File: rtl/clk_disp_scan.sv
// Reads binary hrs/mins once per display frame, converts them to BCD with a sequential
// double-dabble FSM, and scans the four digits onto a multiplexed 7-segment display.
module clk_disp_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [7:0] hrs,
  input  logic [7:0] mins,
  input  logic       colon_en,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int              CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_POL = COMMON_ANODE ? 7'h00 : 7'h7F;
  localparam logic [3:0]      AN_POL  = COMMON_ANODE ? 4'h0 : 4'hF;
  localparam logic            DP_POL  = COMMON_ANODE ? 1'b0 : 1'b1;
  localparam logic [3:0]      DASH    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Active-low segment pattern; any non-decimal code (the DASH marker) lights g only.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One double-dabble iteration on {hundreds, tens, ones, binary}.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    t = {adj(v[19:16]), adj(v[15:12]), adj(v[11:8]), v[7:0]};
    return {t[18:0], 1'b0};
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic             first_r;
  state_t           state_r, state_nx_s;
  logic [2:0]       bit_cnt_r;
  logic [19:0]      hrs_sh_r, mins_sh_r;
  logic [3:0][3:0]  digit_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       an_r;
  logic             wrap_s, frame_start_s, hrs_over_s, mins_over_s;

  assign wrap_s        = (cnt_r == CNT_MAX);
  assign frame_start_s = first_r | (wrap_s & (idx_r == 2'd3));
  assign hrs_over_s    = (hrs_sh_r[19:16] != 4'd0);
  assign mins_over_s   = (mins_sh_r[19:16] != 4'd0);

  // Refresh counter, digit index and the post-reset frame-start flag.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      idx_r   <= 2'd0;
      first_r <= 1'b1;
    end else begin
      first_r <= 1'b0;
      if (wrap_s) begin
        cnt_r <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  state_nx_s = frame_start_s ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_nx_s = ST_SHIFT;
      ST_SHIFT: state_nx_s = (bit_cnt_r == 3'd7) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Conversion datapath; digit registers change only in DONE so a frame is never torn.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= 3'd0;
      hrs_sh_r  <= 20'd0;
      mins_sh_r <= 20'd0;
      digit_r   <= '0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          hrs_sh_r  <= {12'd0, hrs};
          mins_sh_r <= {12'd0, mins};
          bit_cnt_r <= 3'd0;
        end
        ST_SHIFT: begin
          hrs_sh_r  <= dabble_step(hrs_sh_r);
          mins_sh_r <= dabble_step(mins_sh_r);
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        ST_DONE: begin
          digit_r[0] <= mins_over_s ? DASH : mins_sh_r[11:8];
          digit_r[1] <= mins_over_s ? DASH : mins_sh_r[15:12];
          digit_r[2] <= hrs_over_s  ? DASH : hrs_sh_r[11:8];
          digit_r[3] <= hrs_over_s  ? DASH : hrs_sh_r[15:12];
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

  // Registered display drive, one cycle behind the digit index.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= 7'h7F ^ SEG_POL;
      an_r  <= 4'hF ^ AN_POL;
      dp_r  <= 1'b1 ^ DP_POL;
    end else begin
      seg_r <= seg_code(digit_r[idx_r]) ^ SEG_POL;
      an_r  <= (blank ? 4'hF : ~(4'b0001 << idx_r)) ^ AN_POL;
      dp_r  <= ((idx_r == 2'd2) && colon_en ? 1'b0 : 1'b1) ^ DP_POL;
    end
  end

  assign seg = seg_r;
  assign an  = an_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_clk_disp_scan.sv
// Directed bench for clk_disp_scan with REFRESH_DIV=16, common-anode polarity.
module tb_clk_disp_scan;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [7:0] hrs, mins;
  logic       colon_en, blank;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000, SD = 7'b0111111,
                         SOFF = 7'b1111111;

  clk_disp_scan #(.REFRESH_DIV(16), .COMMON_ANODE(1'b1)) dut (
    .CLK(CLK), .rst_n(rst_n), .hrs(hrs), .mins(mins),
    .colon_en(colon_en), .blank(blank), .seg(seg), .dp(dp), .an(an)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    chk({tag, "_an"}, {3'b000, an}, {3'b000, exp_an});
    chk({tag, "_seg"}, seg, exp_seg);
  endtask

  initial begin
    rst_n = 1'b0; hrs = 8'd13; mins = 8'd7; colon_en = 1'b0; blank = 1'b0;
    step(3);
    chk_disp("reset", 4'b1111, SOFF);
    chk("reset_dp", {6'd0, dp}, 7'd1);
    @(negedge CLK); rst_n = 1'b1;

    // E0: first frame starts; digits still cleared.
    step(1);  chk_disp("e0", 4'b1110, S0);
    step(10); chk("e10_no_early", seg, S0);
    step(1);  chk("e11_min_ones", seg, S7);
    step(4);  chk("e15_an_lag", {3'b000, an}, 7'b0001110);
    step(1);  chk_disp("e16_min_tens", 4'b1101, S0);
    step(16); chk_disp("e32_hr_ones", 4'b1011, S3);
    hrs = 8'd23; mins = 8'd59;
    step(16); chk_disp("e48_hr_tens", 4'b0111, S1);
    step(16); chk_disp("e64_old_frame", 4'b1110, S7);
    step(10); chk("e74_new_9", seg, S9);
    step(6);  chk_disp("e80_5", 4'b1101, S5);
    step(16); chk_disp("e96_3", 4'b1011, S3);
    step(16); chk_disp("e112_2", 4'b0111, S2);

    // Out-of-range minutes show dashes only on the minute digits.
    mins = 8'd100;
    step(16); chk_disp("e128_before", 4'b1110, S9);
    step(10); chk("e138_dash_ones", seg, SD);
    step(16); chk_disp("e154_dash_tens", 4'b1101, SD);
    step(16); chk_disp("e170_hr_ok", 4'b1011, S3);
    chk("e170_dp_off", {6'd0, dp}, 7'd1);
    colon_en = 1'b1;
    step(1);  chk("e171_dp_on", {6'd0, dp}, 7'd0);
    mins = 8'd12;
    step(16); chk("e187_dp_slot3", {6'd0, dp}, 7'd1);
    chk("e187_an", {3'b000, an}, 7'b0000111);

    // Change mins while the FSM is shifting: the snapshot (12) must win.
    step(5);  chk_disp("e192_dash", 4'b1110, SD);
    mins = 8'd34;
    step(10); chk("e202_12_ones", seg, S2);
    step(16); chk_disp("e218_12_tens", 4'b1101, S1);
    step(16); chk_disp("e234_hr_ones", 4'b1011, S3);
    chk("e234_dp", {6'd0, dp}, 7'd0);
    step(16); chk_disp("e250_hr_tens", 4'b0111, S2);
    chk("e250_dp", {6'd0, dp}, 7'd1);
    step(16); chk_disp("e266_34_ones", 4'b1110, S4);
    step(16); chk_disp("e282_34_tens", 4'b1101, S3);

    blank = 1'b1;
    step(1);  chk("blank_an", {3'b000, an}, 7'b0001111);
    blank = 1'b0;
    step(1);  chk("unblank_an", {3'b000, an}, 7'b0001101);

    // Reset in the middle of a conversion.
    hrs = 8'd13; mins = 8'd7;
    step(36);
    rst_n = 1'b0;
    #1;
    chk_disp("midrst", 4'b1111, SOFF);
    chk("midrst_dp", {6'd0, dp}, 7'd1);
    @(negedge CLK); @(negedge CLK);
    rst_n = 1'b1;
    step(1);  chk_disp("r_e0_cleared", 4'b1110, S0);
    step(10); chk("r_e10", seg, S0);
    step(1);  chk("r_e11", seg, S7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
